// File: rtl/calc_core.sv
// Keypad-driven decimal calculator: BCD operand entry, multi-cycle arithmetic
// datapath and a double-dabble conversion of the binary result back to BCD.
module calc_core #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [11:0]         sw,
    input  logic [7:0]          dipsw,
    output logic [4*DIGITS-1:0] opa_bcd,
    output logic [4*DIGITS-1:0] opb_bcd,
    output logic [2:0]          op_code,
    output logic [8*DIGITS-1:0] res_bcd,
    output logic                res_neg,
    output logic                err,
    output logic                busy,
    output logic                done,
    output logic [2:0]          state
);
    localparam int W   = $clog2(10 ** DIGITS);
    localparam int RW  = 2 * W;
    localparam int NB  = 4 * DIGITS;
    localparam int RB  = 8 * DIGITS;
    localparam int CW  = $clog2(RW + 1);
    localparam int DCW = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        S_OPA = 3'd0, S_OPB = 3'd1, S_CALC = 3'd2,
        S_CONV = 3'd3, S_DONE = 3'd4, S_ERR = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2,
        OP_MUL = 3'd3, OP_DIV = 3'd4, OP_REM = 3'd5
    } op_t;

    state_t          st, st_n;
    op_t             op_q, key_opc;
    logic [11:0]     sw_q, sw_p;
    logic [7:0]      dip_q, dip_p;
    logic            sw_hit, dip_hit;
    logic            key_digit, key_clr, key_bs, key_op, key_eq;
    logic [3:0]      digit;
    logic [DCW-1:0]  cnt_a, cnt_b;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_bin, b_bin, b_sh;
    logic [W-1:0]    q, q_nxt, r, r_nxt;
    logic [W:0]      r_sh;
    logic [RW-1:0]   p, p_nxt;
    logic            div_by_zero;

    function automatic logic [W-1:0] bcd_to_bin(input logic [NB-1:0] bcd);
        logic [W-1:0] acc;
        acc = '0;
        for (int i = DIGITS - 1; i >= 0; i--)
            acc = W'(32'(acc) * 10 + 32'(bcd[4*i +: 4]));
        return acc;
    endfunction

    function automatic logic [RB-1:0] dabble(input logic [RB-1:0] v, input logic b);
        logic [RB-1:0] t;
        t = v;
        for (int i = 0; i < 2 * DIGITS; i++)
            if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
        return {t[RB-2:0], b};
    endfunction

    // Key edge detection: a key counts only on the first registered sample
    // after an all-released sample; reserved operator bits are masked off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_q  <= '0;
            sw_p  <= '0;
            dip_q <= '0;
            dip_p <= '0;
        end else begin
            sw_q  <= sw;
            sw_p  <= sw_q;
            dip_q <= dipsw & 8'hF9;
            dip_p <= dip_q;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        sw_hit    = $onehot(sw_q) && (sw_p == '0);
        dip_hit   = $onehot(dip_q) && (dip_p == '0) && !sw_hit;
        key_digit = sw_hit && (sw_q[11:2] != '0);
        key_clr   = sw_hit && sw_q[1];
        key_bs    = sw_hit && sw_q[0];
        key_op    = dip_hit && (dip_q[7:3] != '0);
        key_eq    = dip_hit && dip_q[0];
        digit     = '0;
        for (int i = 0; i < 10; i++)
            if (sw_q[11-i]) digit = 4'(i);
        key_opc = OP_NONE;
        if      (dip_q[7]) key_opc = OP_ADD;
        else if (dip_q[6]) key_opc = OP_SUB;
        else if (dip_q[5]) key_opc = OP_MUL;
        else if (dip_q[4]) key_opc = OP_DIV;
        else if (dip_q[3]) key_opc = OP_REM;
    end

    assign a_bin       = bcd_to_bin(opa_bcd);
    assign b_bin       = bcd_to_bin(opb_bcd);
    assign div_by_zero = ((op_q == OP_DIV) || (op_q == OP_REM)) && (b_bin == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= S_OPA;
        else     st <= st_n;
    end

    always_comb begin
        st_n = st;
        if (key_clr) begin
            st_n = S_OPA;
        end else begin
            case (st)
                S_OPA:         if (key_op) st_n = S_OPB;
                S_OPB:         if (key_eq) st_n = div_by_zero ? S_ERR : S_CALC;
                S_CALC:        if (cnt == CW'(W - 1)) st_n = S_CONV;
                S_CONV:        if (cnt == CW'(RW - 1)) st_n = S_DONE;
                S_DONE, S_ERR: if (key_digit) st_n = S_OPA;
                default:       st_n = S_OPA;
            endcase
        end
    end

    // One arithmetic step per CALC cycle; add/sub settle in step 0 and hold.
    always_comb begin
        p_nxt = p;
        q_nxt = q;
        r_nxt = r;
        b_sh  = b_bin >> cnt;
        r_sh  = {r, q[W-1]};
        case (op_q)
            OP_ADD: if (cnt == '0) p_nxt = RW'(a_bin) + RW'(b_bin);
            OP_SUB: if (cnt == '0)
                        p_nxt = (a_bin >= b_bin) ? RW'(a_bin - b_bin) : RW'(b_bin - a_bin);
            OP_MUL: if (b_sh[0]) p_nxt = p + (RW'(a_bin) << cnt);
            OP_DIV, OP_REM: begin
                if (r_sh >= {1'b0, b_bin}) begin
                    r_nxt = W'(r_sh - {1'b0, b_bin});
                    q_nxt = {q[W-2:0], 1'b1};
                end else begin
                    r_nxt = r_sh[W-1:0];
                    q_nxt = {q[W-2:0], 1'b0};
                end
                if (cnt == CW'(W - 1))
                    p_nxt = (op_q == OP_DIV) ? RW'(q_nxt) : RW'(r_nxt);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_bcd <= '0;
            opb_bcd <= '0;
            cnt_a   <= '0;
            cnt_b   <= '0;
            op_q    <= OP_NONE;
            res_bcd <= '0;
            res_neg <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            p       <= '0;
            q       <= '0;
            r       <= '0;
        end else begin
            done <= 1'b0;
            if (key_clr) begin
                opa_bcd <= '0;
                opb_bcd <= '0;
                cnt_a   <= '0;
                cnt_b   <= '0;
                op_q    <= OP_NONE;
                res_bcd <= '0;
                res_neg <= 1'b0;
                err     <= 1'b0;
                cnt     <= '0;
                p       <= '0;
                q       <= '0;
                r       <= '0;
            end else begin
                case (st)
                    S_OPA: begin
                        if (key_digit && (cnt_a < DCW'(DIGITS))) begin
                            opa_bcd <= (opa_bcd << 4) | NB'(digit);
                            cnt_a   <= cnt_a + DCW'(1);
                        end else if (key_bs && (cnt_a != '0)) begin
                            opa_bcd <= opa_bcd >> 4;
                            cnt_a   <= cnt_a - DCW'(1);
                        end else if (key_op) begin
                            op_q <= key_opc;
                        end
                    end
                    S_OPB: begin
                        if (key_digit && (cnt_b < DCW'(DIGITS))) begin
                            opb_bcd <= (opb_bcd << 4) | NB'(digit);
                            cnt_b   <= cnt_b + DCW'(1);
                        end else if (key_bs && (cnt_b != '0)) begin
                            opb_bcd <= opb_bcd >> 4;
                            cnt_b   <= cnt_b - DCW'(1);
                        end else if (key_op && (cnt_b == '0)) begin
                            op_q <= key_opc;
                        end else if (key_eq) begin
                            if (div_by_zero) begin
                                err <= 1'b1;
                            end else begin
                                cnt     <= '0;
                                p       <= '0;
                                q       <= a_bin;
                                r       <= '0;
                                res_neg <= 1'b0;
                            end
                        end
                    end
                    S_CALC: begin
                        p <= p_nxt;
                        q <= q_nxt;
                        r <= r_nxt;
                        if ((op_q == OP_SUB) && (cnt == '0)) res_neg <= (a_bin < b_bin);
                        if (cnt == CW'(W - 1)) begin
                            cnt     <= '0;
                            res_bcd <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_CONV: begin
                        p       <= p << 1;
                        res_bcd <= dabble(res_bcd, p[RW-1]);
                        if (cnt == CW'(RW - 1)) begin
                            cnt  <= '0;
                            done <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    S_DONE, S_ERR: begin
                        if (key_digit) begin
                            opa_bcd <= NB'(digit);
                            cnt_a   <= DCW'(1);
                            opb_bcd <= '0;
                            cnt_b   <= '0;
                            op_q    <= OP_NONE;
                            res_bcd <= '0;
                            res_neg <= 1'b0;
                            err     <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign op_code = op_q;
    assign state   = st;
    assign busy    = (st == S_CALC) || (st == S_CONV);
endmodule

// File: tb/tb_calc_core.sv
// Self-checking bench for calc_core (DIGITS=2): directed scenarios plus a
// randomized key stream compared against a decimal-arithmetic reference model.
module tb_calc_core;
    localparam int DIGITS = 2;
    localparam int W      = 7;
    localparam int RW     = 14;
    localparam int K_CLR = 10, K_BS = 11, K_ADD = 12, K_SUB = 13, K_MUL = 14,
                   K_DIV = 15, K_REM = 16, K_EQ = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] sw = '0;
    logic [7:0]  dipsw = '0;
    logic [7:0]  opa_bcd, opb_bcd;
    logic [2:0]  op_code, state;
    logic [15:0] res_bcd;
    logic        res_neg, err, busy, done;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: operands as plain integers, result as BCD.
    int m_a, m_b, m_na, m_nb, m_op, m_st, m_res, m_neg, m_err;

    calc_core #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .sw(sw), .dipsw(dipsw),
        .opa_bcd(opa_bcd), .opb_bcd(opb_bcd), .op_code(op_code),
        .res_bcd(res_bcd), .res_neg(res_neg), .err(err), .busy(busy),
        .done(done), .state(state)
    );

    always #5 clk = ~clk;

    function automatic int to_bcd(input int v);
        int res = 0;
        for (int i = 0; i < 4; i++) begin
            res = res | ((v % 10) << (4 * i));
            v = v / 10;
        end
        return res;
    endfunction

    function automatic logic [11:0] key_sw(input int k);
        logic [11:0] v = '0;
        if (k <= 9)          v[11-k] = 1'b1;
        else if (k == K_CLR) v[1] = 1'b1;
        else if (k == K_BS)  v[0] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] key_dip(input int k);
        logic [7:0] v = '0;
        if (k >= K_ADD && k <= K_REM) v[7-(k-K_ADD)] = 1'b1;
        else if (k == K_EQ)           v[0] = 1'b1;
        return v;
    endfunction

    task automatic model_clear();
        m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0;
        m_st = 0; m_res = 0; m_neg = 0; m_err = 0;
    endtask

    task automatic model_key(input int k);
        int r;
        if (k == K_CLR) begin
            model_clear();
        end else if (k <= 9) begin
            if (m_st == 0 && m_na < DIGITS) begin
                m_a = m_a * 10 + k; m_na++;
            end else if (m_st == 1 && m_nb < DIGITS) begin
                m_b = m_b * 10 + k; m_nb++;
            end else if (m_st == 4 || m_st == 5) begin
                model_clear(); m_a = k; m_na = 1;
            end
        end else if (k == K_BS) begin
            if (m_st == 0 && m_na > 0) begin
                m_a = m_a / 10; m_na--;
            end else if (m_st == 1 && m_nb > 0) begin
                m_b = m_b / 10; m_nb--;
            end
        end else if (k >= K_ADD && k <= K_REM) begin
            if (m_st == 0) begin
                m_op = k - 11; m_st = 1;
            end else if (m_st == 1 && m_nb == 0) begin
                m_op = k - 11;
            end
        end else if (k == K_EQ && m_st == 1) begin
            if ((m_op == 4 || m_op == 5) && m_b == 0) begin
                m_st = 5; m_err = 1;
            end else begin
                case (m_op)
                    1:       r = m_a + m_b;
                    2:       r = m_a - m_b;
                    3:       r = m_a * m_b;
                    4:       r = m_a / m_b;
                    default: r = m_a % m_b;
                endcase
                m_neg = (r < 0) ? 1 : 0;
                m_res = to_bcd((r < 0) ? -r : r);
                m_st = 4;
            end
        end
    endtask

    task automatic drive_keys(input logic [11:0] s, input logic [7:0] d);
        @(negedge clk);
        sw = s; dipsw = d;
        repeat (2) @(negedge clk);
        sw = '0; dipsw = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input int k);
        drive_keys(key_sw(k), key_dip(k));
        model_key(k);
    endtask

    task automatic wait_end();
        for (int i = 0; i < 60; i++) begin
            if (state == 3'd4 || state == 3'd5) break;
            @(negedge clk);
        end
    endtask

    // Returns at the falling edge just after the DUT has entered CALC.
    task automatic start_equals();
        @(negedge clk);
        dipsw = 8'h01;
        repeat (2) @(negedge clk);
        dipsw = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({state, opa_bcd, opb_bcd, op_code, res_bcd, res_neg, err, busy, done} !== '0) begin
            n_err++;
            $display("FAIL reset_hold: got st=%0d a=%h b=%h op=%0d res=%h neg=%b err=%b busy=%b done=%b, want all zero",
                     state, opa_bcd, opb_bcd, op_code, res_bcd, res_neg, err, busy, done);
        end
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({state, opa_bcd, res_bcd, busy, done} !== '0) begin
            n_err++;
            $display("FAIL reset_release: got st=%0d a=%h res=%h, want zero", state, opa_bcd, res_bcd);
        end
        model_clear();
    endtask

    task automatic test_key_latency();
        press(K_CLR);
        @(negedge clk);
        sw = key_sw(3);
        @(negedge clk);
        n_vec++;
        if (opa_bcd !== 8'h00) begin
            n_err++; $display("FAIL latency_early: opa got %h want 00", opa_bcd);
        end
        @(negedge clk);
        n_vec++;
        if (opa_bcd !== 8'h03) begin
            n_err++; $display("FAIL latency_two: opa got %h want 03", opa_bcd);
        end
        sw = '0;
        repeat (2) @(negedge clk);
        model_key(3);
    endtask

    task automatic test_add_timing();
        press(K_CLR); press(4); press(7);
        n_vec++;
        if (opa_bcd !== 8'h47) begin n_err++; $display("FAIL add_opa: got %h want 47", opa_bcd); end
        press(K_ADD);
        n_vec++;
        if ({op_code, state} !== {3'd1, 3'd1}) begin
            n_err++; $display("FAIL add_op: got op=%0d st=%0d want op=1 st=1", op_code, state);
        end
        press(5); press(8);
        n_vec++;
        if (opb_bcd !== 8'h58) begin n_err++; $display("FAIL add_opb: got %h want 58", opb_bcd); end
        @(negedge clk);
        dipsw = 8'h01;
        @(negedge clk);
        n_vec++;
        if (state !== 3'd1) begin n_err++; $display("FAIL eq_early: st got %0d want 1", state); end
        @(negedge clk);
        dipsw = '0;
        n_vec++;
        if ({state, busy} !== {3'd2, 1'b1}) begin
            n_err++; $display("FAIL eq_calc: got st=%0d busy=%b want st=2 busy=1", state, busy);
        end
        repeat (W + RW - 1) @(negedge clk);
        n_vec++;
        if ({state, done, busy} !== {3'd3, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL conv_last: got st=%0d done=%b busy=%b want st=3 done=0 busy=1", state, done, busy);
        end
        @(negedge clk);
        n_vec++;
        if ({state, done, res_bcd, res_neg} !== {3'd4, 1'b1, 16'h0105, 1'b0}) begin
            n_err++; $display("FAIL add_done: got st=%0d done=%b res=%h neg=%b want st=4 done=1 res=0105 neg=0",
                              state, done, res_bcd, res_neg);
        end
        @(negedge clk);
        n_vec++;
        if ({state, done, busy} !== {3'd4, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL done_pulse: got st=%0d done=%b busy=%b want st=4 done=0 busy=0", state, done, busy);
        end
        model_key(K_EQ);
    endtask

    task automatic test_arith();
        press(K_CLR); press(1); press(2); press(K_SUB); press(3); press(0); press(K_EQ);
        wait_end();
        n_vec++;
        if ({state, res_bcd, res_neg} !== {3'd4, 16'h0018, 1'b1}) begin
            n_err++; $display("FAIL sub_neg: got st=%0d res=%h neg=%b want st=4 res=0018 neg=1", state, res_bcd, res_neg);
        end
        press(9); press(9); press(K_MUL); press(9); press(9); press(K_EQ);
        wait_end();
        n_vec++;
        if ({state, res_bcd, res_neg} !== {3'd4, 16'h9801, 1'b0}) begin
            n_err++; $display("FAIL mul_max: got st=%0d res=%h neg=%b want st=4 res=9801 neg=0", state, res_bcd, res_neg);
        end
        press(5);
        n_vec++;
        if ({state, opa_bcd, opb_bcd, op_code, res_bcd} !== {3'd0, 8'h05, 8'h00, 3'd0, 16'h0000}) begin
            n_err++; $display("FAIL done_digit: got st=%0d a=%h b=%h op=%0d res=%h want st=0 a=05 b=00 op=0 res=0000",
                              state, opa_bcd, opb_bcd, op_code, res_bcd);
        end
        press(0); press(K_REM); press(7); press(K_EQ);
        wait_end();
        n_vec++;
        if ({state, res_bcd} !== {3'd4, 16'h0001}) begin
            n_err++; $display("FAIL rem: got st=%0d res=%h want st=4 res=0001", state, res_bcd);
        end
        press(9); press(9); press(K_ADD); press(9); press(9); press(K_EQ);
        wait_end();
        n_vec++;
        if ({state, res_bcd} !== {3'd4, 16'h0198}) begin
            n_err++; $display("FAIL add_max: got st=%0d res=%h want st=4 res=0198", state, res_bcd);
        end
    endtask

    task automatic test_div_zero();
        press(8); press(K_DIV); press(K_EQ);
        n_vec++;
        if ({state, err, res_bcd, res_neg} !== {3'd5, 1'b1, 16'h0000, 1'b0}) begin
            n_err++; $display("FAIL div0: got st=%0d err=%b res=%h neg=%b want st=5 err=1 res=0000 neg=0",
                              state, err, res_bcd, res_neg);
        end
        press(K_ADD); press(K_BS);
        n_vec++;
        if ({state, err, op_code} !== {3'd5, 1'b1, 3'd4}) begin
            n_err++; $display("FAIL err_ignore: got st=%0d err=%b op=%0d want st=5 err=1 op=4", state, err, op_code);
        end
        press(3);
        n_vec++;
        if ({state, opa_bcd, err, op_code} !== {3'd0, 8'h03, 1'b0, 3'd0}) begin
            n_err++; $display("FAIL err_digit: got st=%0d a=%h err=%b op=%0d want st=0 a=03 err=0 op=0",
                              state, opa_bcd, err, op_code);
        end
    endtask

    task automatic test_entry();
        press(K_CLR); press(1); press(2); press(3);
        n_vec++;
        if (opa_bcd !== 8'h12) begin n_err++; $display("FAIL digit_limit: got %h want 12", opa_bcd); end
        press(K_BS);
        n_vec++;
        if (opa_bcd !== 8'h01) begin n_err++; $display("FAIL backspace: got %h want 01", opa_bcd); end
        drive_keys(12'h0C00, 8'h00);
        n_vec++;
        if ({state, opa_bcd} !== {3'd0, 8'h01}) begin
            n_err++; $display("FAIL multi_hot: got st=%0d a=%h want st=0 a=01", state, opa_bcd);
        end
        press(K_BS); press(K_BS); press(K_EQ);
        n_vec++;
        if ({state, opa_bcd} !== {3'd0, 8'h00}) begin
            n_err++; $display("FAIL bs_empty_eq: got st=%0d a=%h want st=0 a=00", state, opa_bcd);
        end
        drive_keys(key_sw(5), key_dip(K_ADD));
        model_key(5);
        n_vec++;
        if ({state, opa_bcd, op_code} !== {3'd0, 8'h05, 3'd0}) begin
            n_err++; $display("FAIL sw_priority: got st=%0d a=%h op=%0d want st=0 a=05 op=0", state, opa_bcd, op_code);
        end
        press(K_ADD); press(K_SUB);
        n_vec++;
        if (op_code !== 3'd2) begin n_err++; $display("FAIL op_replace: got %0d want 2", op_code); end
        press(2); press(K_MUL); press(K_EQ);
        wait_end();
        n_vec++;
        if ({op_code, res_bcd, res_neg} !== {3'd2, 16'h0003, 1'b0}) begin
            n_err++; $display("FAIL op_locked: got op=%0d res=%h neg=%b want op=2 res=0003 neg=0", op_code, res_bcd, res_neg);
        end
    endtask

    task automatic test_abort();
        logic saw_done;
        press(K_CLR); press(2); press(K_MUL); press(3);
        start_equals();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({state, busy} !== {3'd2, 1'b1}) begin
            n_err++; $display("FAIL mid_calc: got st=%0d busy=%b want st=2 busy=1", state, busy);
        end
        sw = key_sw(K_CLR);
        repeat (2) @(negedge clk);
        sw = '0;
        n_vec++;
        if ({state, opa_bcd, opb_bcd, op_code, res_bcd, res_neg, err, busy} !== '0) begin
            n_err++; $display("FAIL clear_calc: got st=%0d a=%h b=%h op=%0d res=%h busy=%b want all zero",
                              state, opa_bcd, opb_bcd, op_code, res_bcd, busy);
        end
        model_clear();
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        n_vec++;
        if (saw_done !== 1'b0) begin n_err++; $display("FAIL clear_no_done: done pulse seen, want none"); end
        sw = key_sw(7);
        repeat (10) @(negedge clk);
        sw = '0;
        repeat (2) @(negedge clk);
        model_key(7);
        n_vec++;
        if (opa_bcd !== 8'h07) begin n_err++; $display("FAIL held_key: got %h want 07", opa_bcd); end
        press(K_ADD); press(4);
        start_equals();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        n_vec++;
        if ({state, opa_bcd, opb_bcd, op_code, busy} !== '0) begin
            n_err++; $display("FAIL reset_calc: got st=%0d a=%h b=%h op=%0d busy=%b want all zero",
                              state, opa_bcd, opb_bcd, op_code, busy);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            saw_done = saw_done | done;
        end
        n_vec++;
        if (saw_done !== 1'b0) begin n_err++; $display("FAIL reset_no_done: done pulse seen, want none"); end
    endtask

    task automatic test_random();
        logic [39:0] exp_v, got_v;
        int sel, k;
        press(K_CLR);
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 48)      k = $urandom_range(0, 9);
            else if (sel < 68) k = K_ADD + $urandom_range(0, 4);
            else if (sel < 82) k = K_EQ;
            else if (sel < 92) k = K_BS;
            else if (sel < 95) k = K_CLR;
            else               k = -1;
            if (k < 0) drive_keys(key_sw($urandom_range(0, 9)) | 12'h003, 8'h00);
            else       press(k);
            if (m_st == 4) wait_end();
            exp_v = {8'(to_bcd(m_a)), 8'(to_bcd(m_b)), 3'(m_op), 3'(m_st), 16'(m_res), 1'(m_neg), 1'(m_err)};
            got_v = {opa_bcd, opb_bcd, op_code, state, res_bcd, res_neg, err};
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL random[%0d] key=%0d: got a=%h b=%h op=%0d st=%0d res=%h neg=%b err=%b, want a=%h b=%h op=%0d st=%0d res=%h neg=%b err=%b",
                         i, k, got_v[39:32], got_v[31:24], got_v[23:21], got_v[20:18], got_v[17:2], got_v[1], got_v[0],
                         exp_v[39:32], exp_v[31:24], exp_v[23:21], exp_v[20:18], exp_v[17:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_key_latency();
        test_add_timing();
        test_arith();
        test_div_zero();
        test_entry();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
